// File: rtl/tt_aseq_pkg.sv
// Shared types and source codes for the analog pin sequencer.
// Optional readback port is enabled with TT_ASEQ_READBACK_EN.
package tt_aseq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BREAK  = 2'd1,
        SETTLE = 2'd2,
        MAKE   = 2'd3
    } aseq_state_t;

    localparam int SRC_OPEN  = 0;
    localparam int SRC_VAPWR = 1;
    localparam int SRC_VDPWR = 2;
    localparam int SRC_VGND  = 3;

endpackage

// File: rtl/tt_aseq_settle_timer.sv
// Loadable down-counter timing the open gap between break and make.
module tt_aseq_settle_timer
    import tt_aseq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic         expired,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (dec && cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == W'(1));
    assign zero    = (cnt_q == '0);

endmodule

// File: rtl/tt_analog_pin_seq.sv
// Break-before-make switch sequencer for the analog pin ring.
// Define TT_ASEQ_READBACK_EN to add the rd_ch/rd_src readback port.
module tt_analog_pin_seq
    import tt_aseq_pkg::*;
#(
    parameter int N_CH     = 6,
    parameter int NSRC     = 3,
    parameter int SEL_W    = $clog2(NSRC + 1),
    parameter int SETTLE_W = 8,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [CH_W-1:0]        wr_ch,
    input  logic [SEL_W-1:0]       wr_src,
    input  logic                   commit,
    input  logic [SETTLE_W-1:0]    settle,
    output logic [N_CH*NSRC-1:0]   sw_on,
    output logic                   busy,
    output logic                   done,
    output logic                   err
`ifdef TT_ASEQ_READBACK_EN
    ,
    input  logic [CH_W-1:0]        rd_ch,
    output logic [SEL_W-1:0]       rd_src
`endif
);

    localparam logic [CH_W:0]  NCH_L  = (CH_W + 1)'(N_CH);
    localparam logic [SEL_W:0] NSRC_L = (SEL_W + 1)'(NSRC);

    aseq_state_t state_q, state_d;
    logic [SEL_W-1:0] shadow_q [N_CH];
    logic [SEL_W-1:0] shadow_d [N_CH];
    logic [SEL_W-1:0] active_q [N_CH];
    logic [SEL_W-1:0] active_d [N_CH];
    logic [N_CH-1:0] chg_q, chg_d;
    logic [N_CH*NSRC-1:0] sw_on_q, sw_on_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic err_q, err_d;
    logic wr_ok;
    logic tmr_load, tmr_dec, tmr_expired, tmr_zero;

    tt_aseq_settle_timer #(.W(SETTLE_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .value   (settle),
        .dec     (tmr_dec),
        .expired (tmr_expired),
        .zero    (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        chg_d    = chg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        sw_on_d  = '0;

        wr_ok = wr_en && (state_q == IDLE)
             && ({1'b0, wr_ch} < NCH_L)
             && ({1'b0, wr_src} <= NSRC_L);

        for (int i = 0; i < N_CH; i++) begin
            if (wr_ok && wr_ch == CH_W'(i)) begin
                shadow_d[i] = wr_src;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (commit) begin
                    tmr_load = 1'b1;
                    err_d    = 1'b0;
                    // Compare against the post-write shadow so a same-cycle write is included
                    for (int i = 0; i < N_CH; i++) begin
                        chg_d[i] = (shadow_d[i] != active_q[i]);
                    end
                    if (chg_d != '0) begin
                        state_d = BREAK;
                        busy_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            BREAK: begin
                for (int i = 0; i < N_CH; i++) begin
                    if (chg_q[i]) begin
                        active_d[i] = SEL_W'(SRC_OPEN);
                    end
                end
                state_d = tmr_zero ? MAKE : SETTLE;
            end
            SETTLE: begin
                if (tmr_expired) begin
                    state_d = MAKE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            MAKE: begin
                for (int i = 0; i < N_CH; i++) begin
                    if (chg_q[i]) begin
                        active_d[i] = shadow_q[i];
                    end
                end
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        endcase

        if (wr_en && !wr_ok) begin
            err_d = 1'b1;
        end

        for (int c = 0; c < N_CH; c++) begin
            for (int k = 0; k < NSRC; k++) begin
                sw_on_d[c*NSRC + k] = (active_d[c] == SEL_W'(k + 1));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shadow_q <= '{default: '0};
            active_q <= '{default: '0};
            chg_q    <= '0;
            sw_on_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            chg_q    <= chg_d;
            sw_on_q  <= sw_on_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign sw_on = sw_on_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

`ifdef TT_ASEQ_READBACK_EN
    logic [SEL_W-1:0] rd_src_q, rd_src_d;

    always_comb begin
        rd_src_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                rd_src_d = active_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_src_q <= '0;
        end else begin
            rd_src_q <= rd_src_d;
        end
    end

    assign rd_src = rd_src_q;
`endif

endmodule

// File: tb/tb_tt_analog_pin_seq.sv
// Self-checking bench for tt_analog_pin_seq: timed reference model
// plus directed scenarios with literal expectations.
module tb_tt_analog_pin_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_ch;
    logic [1:0]  wr_src;
    logic        commit;
    logic [7:0]  settle;
    logic [17:0] sw_on;
    logic        busy, done, err;
    logic [2:0]  rd_ch;
    logic [1:0]  rd_src;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 0;

    always #5 clk = ~clk;

    tt_analog_pin_seq dut (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_src (wr_src),
        .commit (commit),
        .settle (settle),
        .sw_on  (sw_on),
        .busy   (busy),
        .done   (done),
        .err    (err)
`ifdef TT_ASEQ_READBACK_EN
        ,
        .rd_ch  (rd_ch),
        .rd_src (rd_src)
`endif
    );

    // Reference model: sequence described by its commit cycle and settle time
    int         cyc = 0;
    logic [1:0] m_sh  [6];
    logic [1:0] m_act [6];
    bit   [5:0] m_chg;
    bit         seq_on;
    int         s_t, s_s;
    int         done_at = -1;
    bit         m_err;

    function automatic bit m_busy(int c);
        return seq_on && c >= s_t + 1 && c <= s_t + 2 + s_s;
    endfunction

    function automatic logic [1:0] exp_act(int ch, int c);
        if (seq_on && m_chg[ch] && c >= s_t + 2) return 2'd0;
        return m_act[ch];
    endfunction

    function automatic logic [17:0] exp_sw(int c);
        logic [17:0] v = '0;
        for (int ch = 0; ch < 6; ch++)
            for (int k = 0; k < 3; k++)
                if (int'(exp_act(ch, c)) == k + 1) v[ch*3 + k] = 1'b1;
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) begin
                m_sh[i]  = 2'd0;
                m_act[i] = 2'd0;
            end
            m_chg   = '0;
            seq_on  = 0;
            done_at = -1;
            m_err   = 0;
        end else begin
            int c;
            bit bz, wok;
            c   = cyc;
            bz  = m_busy(c);
            wok = wr_en && !bz && wr_ch < 3'd6;
            if (wok) m_sh[wr_ch] = wr_src;
            if (commit && !bz) begin
                m_err = 0;
                m_chg = '0;
                for (int i = 0; i < 6; i++)
                    if (m_sh[i] != m_act[i]) m_chg[i] = 1'b1;
                if (m_chg != '0) begin
                    seq_on  = 1;
                    s_t     = c;
                    s_s     = int'(settle);
                    done_at = c + 3 + int'(settle);
                end else begin
                    done_at = c + 1;
                end
            end
            if (wr_en && !wok) m_err = 1;
            if (seq_on && c == s_t + 2 + s_s) begin
                for (int i = 0; i < 6; i++)
                    if (m_chg[i]) m_act[i] = m_sh[i];
                seq_on = 0;
            end
            cyc = c + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on && !rst) begin
            chk("model_sw_on", 32'(sw_on), 32'(exp_sw(cyc)));
            chk("model_busy", 32'(busy), 32'(m_busy(cyc)));
            chk("model_done", 32'(done), 32'(cyc == done_at));
            chk("model_err", 32'(err), 32'(m_err));
        end
    end

    task automatic cmd(input logic we, input logic [2:0] ch, input logic [1:0] src,
                       input logic cm, input logic [7:0] st, output int t);
        @(posedge clk); #2;
        wr_en = we; wr_ch = ch; wr_src = src; commit = cm; settle = st;
        t = cyc;
        @(posedge clk); #2;
        wr_en = 0; wr_ch = 0; wr_src = 0; commit = 0; settle = 0;
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        @(negedge clk);
        while (!done && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 32'(done), 32'd1);
    endtask

    initial begin
        int t, t2, nb;
        rst = 1; wr_en = 0; wr_ch = 0; wr_src = 0;
        commit = 0; settle = 0; rd_ch = 0;
        repeat (3) @(posedge clk);
        #2 rst = 0;
        chk_on = 1;
        @(negedge clk);
        chk("rst_sw_on", 32'(sw_on), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_err", 32'({done, err}), 32'd0);

        // ch0 -> VAPWR, ch1 -> VDPWR, settle 4
        cmd(1, 3'd0, 2'd1, 0, 8'd0, t);
        cmd(1, 3'd1, 2'd2, 0, 8'd0, t);
        cmd(0, 3'd0, 2'd0, 1, 8'd4, t);
        nb = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            nb += int'(busy);
            if (cyc == t + 6) chk("s1_sw_before", 32'(sw_on), 32'h0);
            if (cyc == t + 7) begin
                chk("s1_sw_on", 32'(sw_on), 32'h11);
                chk("s1_done", 32'(done), 32'd1);
            end
        end
        chk("s1_busy_cycles", 32'(nb), 32'd6);

`ifdef TT_ASEQ_READBACK_EN
        rd_ch = 3'd1;
        @(posedge clk); #1;
        chk("rb_ch1", 32'(rd_src), 32'd2);
        rd_ch = 3'd7;
        @(posedge clk); #1;
        chk("rb_ch7", 32'(rd_src), 32'd0);
`endif

        // ch0 1 -> 3 written in the commit cycle, settle 0
        cmd(1, 3'd0, 2'd3, 1, 8'd0, t);
        @(negedge clk);
        chk("s2_t1_sw", 32'(sw_on), 32'h11);
        @(negedge clk);
        chk("s2_t2_sw", 32'(sw_on), 32'h10);
        @(negedge clk);
        chk("s2_t3_sw", 32'(sw_on), 32'h14);
        chk("s2_t3_done", 32'(done), 32'd1);

        // no-change commit
        cmd(0, 3'd0, 2'd0, 1, 8'd9, t);
        @(negedge clk);
        chk("s3_done", 32'(done), 32'd1);
        chk("s3_busy", 32'(busy), 32'd0);
        chk("s3_sw", 32'(sw_on), 32'h14);
        @(negedge clk);
        chk("s3_done_pulse", 32'(done), 32'd0);

        // illegal channel, then commit clears err without any change
        cmd(1, 3'd6, 2'd1, 0, 8'd0, t);
        @(negedge clk);
        chk("s4_err_ch6", 32'(err), 32'd1);
        cmd(0, 3'd0, 2'd0, 1, 8'd0, t);
        @(negedge clk);
        chk("s4_clr_done", 32'(done), 32'd1);
        chk("s4_clr_err", 32'(err), 32'd0);
        cmd(1, 3'd7, 2'd2, 0, 8'd0, t);
        @(negedge clk);
        chk("s4_err_ch7", 32'(err), 32'd1);

        // write and commit while busy are dropped
        cmd(1, 3'd2, 2'd3, 1, 8'd5, t);
        cmd(1, 3'd2, 2'd1, 1, 8'd0, t2);
        @(negedge clk);
        chk("s4_err_busy", 32'(err), 32'd1);
        wait_done("s4_seq_done");
        chk("s4_sw", 32'(sw_on), 32'h114);
        cmd(0, 3'd0, 2'd0, 1, 8'd0, t);
        @(negedge clk);
        chk("s4_nochg_done", 32'(done), 32'd1);
        chk("s4_nochg_busy", 32'(busy), 32'd0);
        chk("s4_err_cleared", 32'(err), 32'd0);

        // reset during a long settle
        cmd(1, 3'd3, 2'd2, 1, 8'd200, t);
        repeat (10) @(posedge clk);
        #2 rst = 1;
        #1;
        chk("s5_rst_sw", 32'(sw_on), 32'd0);
        chk("s5_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 0;
        cmd(1, 3'd0, 2'd2, 1, 8'd2, t);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (cyc == t + 5) begin
                chk("s5_after_sw", 32'(sw_on), 32'h2);
                chk("s5_after_done", 32'(done), 32'd1);
            end
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
